// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the pipelined RISC-V immediate generator.
// The format code travels with every decoded instruction through the skid and output registers.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == F3_SLL) || (funct3 == F3_SRX);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder: instruction word -> sign-extended immediate, format, unknown flag.
// Sits ahead of the skid buffer so both buffer entries already hold decoded data.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output fmt_e            o_fmt,
  output logic            o_unknown
);

  localparam bit X64 = (XLEN == 64);

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic signed [31:0] w_imm32;
  logic [31:0]       w_imm_i;
  logic [31:0]       w_shamt;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  // RV64 OP-IMM shifts carry a 6-bit shamt; OP-IMM-32 and RV32 shifts only 5 bits.
  assign w_shamt  = (X64 && (w_opcode == OPC_OP_IMM)) ? {26'd0, i_instr[25:20]}
                                                      : {27'd0, i_instr[24:20]};

  // Format selection and 32-bit immediate assembly
  always_comb begin
    w_imm32   = 32'sd0;
    o_fmt     = FMT_NONE;
    o_unknown = 1'b1;
    case (w_opcode)
      OPC_LOAD, OPC_JALR: begin
        w_imm32   = w_imm_i;
        o_fmt     = FMT_I;
        o_unknown = 1'b0;
      end
      OPC_OP_IMM: begin
        o_fmt     = FMT_I;
        o_unknown = 1'b0;
        if (is_shift(w_funct3)) begin
          w_imm32 = w_shamt;
        end else begin
          w_imm32 = w_imm_i;
        end
      end
      OPC_OP_IMM_32: begin
        if (X64) begin
          o_fmt     = FMT_I;
          o_unknown = 1'b0;
          if (is_shift(w_funct3)) begin
            w_imm32 = w_shamt;
          end else begin
            w_imm32 = w_imm_i;
          end
        end else begin
          w_imm32   = 32'sd0;
          o_fmt     = FMT_NONE;
          o_unknown = 1'b1;
        end
      end
      OPC_STORE: begin
        w_imm32   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        o_fmt     = FMT_S;
        o_unknown = 1'b0;
      end
      OPC_BRANCH: begin
        w_imm32   = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        o_fmt     = FMT_B;
        o_unknown = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_imm32   = {i_instr[31:12], 12'd0};
        o_fmt     = FMT_U;
        o_unknown = 1'b0;
      end
      OPC_JAL: begin
        w_imm32   = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        o_fmt     = FMT_J;
        o_unknown = 1'b0;
      end
      OPC_OP: begin
        o_fmt     = FMT_R;
        o_unknown = 1'b0;
      end
      OPC_OP_32: begin
        if (X64) begin
          o_fmt     = FMT_R;
          o_unknown = 1'b0;
        end else begin
          o_fmt     = FMT_NONE;
          o_unknown = 1'b1;
        end
      end
      default: begin
        w_imm32   = 32'sd0;
        o_fmt     = FMT_NONE;
        o_unknown = 1'b1;
      end
    endcase
  end

  assign o_imm = XLEN'(w_imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, handshaked immediate generator with a 2-entry (output + skid) buffer.
// Also keeps a saturating count of accepted unknown opcodes for debug.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_unknown,
  output logic [TAG_W-1:0] out_tag,
  input  logic             clr_count,
  output logic [CNT_W-1:0] unk_count
);

  logic [XLEN-1:0]  w_dec_imm;
  fmt_e             w_dec_fmt;
  logic             w_dec_unknown;
  logic             w_accept;
  logic             w_out_load;

  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_imm;
  fmt_e             r_out_fmt;
  logic             r_out_unknown;
  logic [TAG_W-1:0] r_out_tag;

  logic             r_skid_valid;
  logic [XLEN-1:0]  r_skid_imm;
  fmt_e             r_skid_fmt;
  logic             r_skid_unknown;
  logic [TAG_W-1:0] r_skid_tag;

  logic [CNT_W-1:0] r_unk_count;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .i_instr   (in_instr),
    .o_imm     (w_dec_imm),
    .o_fmt     (w_dec_fmt),
    .o_unknown (w_dec_unknown)
  );

  assign w_accept   = in_valid & ~r_skid_valid;
  assign w_out_load = ~r_out_valid | out_ready;

  // Output register: skid has priority so order is preserved
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_imm     <= {XLEN{1'b0}};
      r_out_fmt     <= FMT_NONE;
      r_out_unknown <= 1'b0;
      r_out_tag     <= {TAG_W{1'b0}};
    end else if (w_out_load) begin
      if (r_skid_valid) begin
        r_out_valid   <= 1'b1;
        r_out_imm     <= r_skid_imm;
        r_out_fmt     <= r_skid_fmt;
        r_out_unknown <= r_skid_unknown;
        r_out_tag     <= r_skid_tag;
      end else if (w_accept) begin
        r_out_valid   <= 1'b1;
        r_out_imm     <= w_dec_imm;
        r_out_fmt     <= w_dec_fmt;
        r_out_unknown <= w_dec_unknown;
        r_out_tag     <= in_tag;
      end else begin
        r_out_valid   <= 1'b0;
      end
    end
  end

  // Skid entry: captures an accepted instruction while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_valid   <= 1'b0;
      r_skid_imm     <= {XLEN{1'b0}};
      r_skid_fmt     <= FMT_NONE;
      r_skid_unknown <= 1'b0;
      r_skid_tag     <= {TAG_W{1'b0}};
    end else if (r_skid_valid) begin
      if (w_out_load) begin
        r_skid_valid <= 1'b0;
      end
    end else if (w_accept && !w_out_load) begin
      r_skid_valid   <= 1'b1;
      r_skid_imm     <= w_dec_imm;
      r_skid_fmt     <= w_dec_fmt;
      r_skid_unknown <= w_dec_unknown;
      r_skid_tag     <= in_tag;
    end
  end

  // Unknown-opcode counter; a clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_unk_count <= {CNT_W{1'b0}};
    end else if (clr_count) begin
      r_unk_count <= {CNT_W{1'b0}};
    end else if (w_accept && w_dec_unknown && (r_unk_count != {CNT_W{1'b1}})) begin
      r_unk_count <= r_unk_count + CNT_W'(1'b1);
    end
  end

  assign in_ready    = ~r_skid_valid;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_out_imm;
  assign out_fmt     = r_out_fmt;
  assign out_unknown = r_out_unknown;
  assign out_tag     = r_out_tag;
  assign unk_count   = r_unk_count;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 stream/backpressure/reset, XLEN=64 decode, CNT_W=2 saturation.
// Expected values come from spec constants and an arithmetic reference decoder with a queue scoreboard.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: XLEN=32, CNT_W=16
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_unknown, a_clr;
  logic [31:0] a_in_instr, a_in_tag, a_out_imm, a_out_tag;
  logic [2:0]  a_out_fmt;
  logic [15:0] a_cnt;
  // Instance B: XLEN=64
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_unknown, b_clr;
  logic [31:0] b_in_instr;
  logic [7:0]  b_in_tag, b_out_tag;
  logic [63:0] b_out_imm;
  logic [2:0]  b_out_fmt;
  logic [15:0] b_cnt;
  // Instance C: CNT_W=2
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_unknown, c_clr;
  logic [31:0] c_in_instr, c_out_imm;
  logic [7:0]  c_in_tag, c_out_tag;
  logic [2:0]  c_out_fmt;
  logic [1:0]  c_cnt;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr),
    .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
    .out_fmt(a_out_fmt), .out_unknown(a_out_unknown), .out_tag(a_out_tag), .clr_count(a_clr),
    .unk_count(a_cnt));
  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
    .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
    .out_fmt(b_out_fmt), .out_unknown(b_out_unknown), .out_tag(b_out_tag), .clr_count(b_clr),
    .unk_count(b_cnt));
  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_instr(c_in_instr),
    .in_tag(c_in_tag), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_imm(c_out_imm),
    .out_fmt(c_out_fmt), .out_unknown(c_out_unknown), .out_tag(c_out_tag), .clr_count(c_clr),
    .unk_count(c_cnt));

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        unk;
  } dec_t;

  typedef struct {
    dec_t        d;
    logic [31:0] tag;
  } exp_t;

  // Reference decoder: field values interpreted as signed integers, scaled arithmetically.
  function automatic dec_t ref_decode(input logic [31:0] ins, input bit x64);
    dec_t d;
    longint v;
    logic [6:0] op;
    bit shift;
    op = ins[6:0];
    shift = (ins[14:12] == 3'd1) || (ins[14:12] == 3'd5);
    v = 0;
    d.unk = 1'b0;
    if (op == 7'h03 || op == 7'h67 || ((op == 7'h13 || (x64 && op == 7'h1B)) && !shift)) begin
      v = $signed(ins[31:20]);
      d.fmt = 3'd1;
    end else if (op == 7'h13 || (x64 && op == 7'h1B)) begin
      v = (x64 && op == 7'h13) ? ins[25:20] : ins[24:20];
      d.fmt = 3'd1;
    end else if (op == 7'h23) begin
      v = $signed({ins[31:25], ins[11:7]});
      d.fmt = 3'd2;
    end else if (op == 7'h63) begin
      v = $signed({ins[31], ins[7], ins[30:25], ins[11:8]});
      v = v * 2;
      d.fmt = 3'd3;
    end else if (op == 7'h37 || op == 7'h17) begin
      v = $signed(ins[31:12]);
      v = v * 4096;
      d.fmt = 3'd4;
    end else if (op == 7'h6F) begin
      v = $signed({ins[31], ins[19:12], ins[20], ins[30:21]});
      v = v * 2;
      d.fmt = 3'd5;
    end else if (op == 7'h33 || (x64 && op == 7'h3B)) begin
      d.fmt = 3'd0;
    end else begin
      d.fmt = 3'd7;
      d.unk = 1'b1;
    end
    d.imm = v;
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [14] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h0F, 7'h13};
    logic [31:0] r;
    r = $urandom();
    r[6:0] = ops[$urandom_range(0, 13)];
    return r;
  endfunction

  // Scoreboard for instance A: pushes on accept, pops on output handshake, checks stall stability
  exp_t        sb_q[$];
  exp_t        sb_e;
  dec_t        sb_d;
  logic        stall_r;
  logic [31:0] st_imm, st_tag;
  logic [2:0]  st_fmt;
  logic        st_unk;

  initial begin
    stall_r = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        stall_r = 1'b0;
      end else begin
        if (stall_r) begin
          n_tests++;
          if (a_out_valid !== 1'b1 || a_out_imm !== st_imm || a_out_fmt !== st_fmt ||
              a_out_unknown !== st_unk || a_out_tag !== st_tag) begin
            n_fail++;
            $display("FAIL sb_stable: got v=%b imm=%h fmt=%0d tag=%h, expected v=1 imm=%h fmt=%0d tag=%h",
                     a_out_valid, a_out_imm, a_out_fmt, a_out_tag, st_imm, st_fmt, st_tag);
          end
        end
        if (a_out_valid === 1'b1 && a_out_ready) begin
          n_tests++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra: got output tag=%h, expected no output", a_out_tag);
          end else begin
            sb_e = sb_q.pop_front();
            if (a_out_imm !== sb_e.d.imm[31:0] || a_out_fmt !== sb_e.d.fmt ||
                a_out_unknown !== sb_e.d.unk || a_out_tag !== sb_e.tag) begin
              n_fail++;
              $display("FAIL sb_data: got imm=%h fmt=%0d unk=%b tag=%h, expected imm=%h fmt=%0d unk=%b tag=%h",
                       a_out_imm, a_out_fmt, a_out_unknown, a_out_tag,
                       sb_e.d.imm[31:0], sb_e.d.fmt, sb_e.d.unk, sb_e.tag);
            end
          end
        end
        stall_r = (a_out_valid === 1'b1) && !a_out_ready;
        st_imm = a_out_imm; st_fmt = a_out_fmt; st_unk = a_out_unknown; st_tag = a_out_tag;
        if (a_in_valid && a_in_ready === 1'b1) begin
          sb_d = ref_decode(a_in_instr, 1'b0);
          sb_e.d = sb_d;
          sb_e.tag = a_in_tag;
          sb_q.push_back(sb_e);
        end
      end
    end
  end

  logic [31:0] s_in  [5] = '{32'hFFC12083, 32'h00512423, 32'hFE000CE3, 32'h123450B7, 32'h001000EF};
  logic [31:0] s_imm [5] = '{32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFF8, 32'h12345000, 32'h00000800};
  logic [2:0]  s_fmt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_instr = 32'd0; a_in_tag = 32'd0; a_out_ready = 1'b1; a_clr = 1'b0;
    b_in_valid = 1'b0; b_in_instr = 32'd0; b_in_tag = 8'd0; b_out_ready = 1'b1; b_clr = 1'b0;
    c_in_valid = 1'b0; c_in_instr = 32'd0; c_in_tag = 8'd0; c_out_ready = 1'b1; c_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_imm !== 32'd0 || a_out_fmt !== 3'd7 ||
        a_out_unknown !== 1'b0 || a_out_tag !== 32'd0 || a_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_a: got v=%b rdy=%b imm=%h fmt=%0d unk=%b tag=%h cnt=%0d, expected 0 1 0 7 0 0 0",
               a_out_valid, a_in_ready, a_out_imm, a_out_fmt, a_out_unknown, a_out_tag, a_cnt);
    end
    n_tests++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_out_imm !== 64'd0 || c_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_bc: got bv=%b brdy=%b bimm=%h ccnt=%0d, expected 0 1 0 0",
               b_out_valid, b_in_ready, b_out_imm, c_cnt);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stream();
    a_out_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(posedge clk); #1;
      a_in_valid = (i < 5);
      a_in_instr = (i < 5) ? s_in[i] : 32'd0;
      a_in_tag   = 32'd100 + 32'(i);
      @(negedge clk);
      if (i < 5) begin
        n_tests++;
        if (a_in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_ready[%0d]: got %b, expected 1", i, a_in_ready);
        end
      end
      if (i > 0) begin
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_imm !== s_imm[i-1] || a_out_fmt !== s_fmt[i-1]) begin
          n_fail++;
          $display("FAIL stream_out[%0d]: got v=%b imm=%h fmt=%0d, expected v=1 imm=%h fmt=%0d",
                   i - 1, a_out_valid, a_out_imm, a_out_fmt, s_imm[i-1], s_fmt[i-1]);
        end
      end
    end
    a_in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_shifts();
    logic [31:0] ins [3] = '{32'h4030D093, 32'h02109093, 32'hFFF00093};
    logic [63:0] exp [3] = '{64'd3, 64'd33, 64'hFFFFFFFFFFFFFFFF};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin a_in_valid = 1'b1; a_in_instr = ins[i]; a_in_tag = 32'h5; end
      else begin b_in_valid = 1'b1; b_in_instr = ins[i]; b_in_tag = 8'(i); end
      @(posedge clk); #1;
      a_in_valid = 1'b0; b_in_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (i == 0) begin
        if (a_out_valid !== 1'b1 || a_out_imm !== exp[i][31:0] || a_out_fmt !== 3'd1) begin
          n_fail++;
          $display("FAIL shift32: got v=%b imm=%h fmt=%0d, expected v=1 imm=%h fmt=1",
                   a_out_valid, a_out_imm, a_out_fmt, exp[i][31:0]);
        end
      end else if (b_out_valid !== 1'b1 || b_out_imm !== exp[i] || b_out_fmt !== 3'd1 ||
                   b_out_tag !== 8'(i)) begin
        n_fail++;
        $display("FAIL shift64[%0d]: got v=%b imm=%h fmt=%0d tag=%0d, expected v=1 imm=%h fmt=1 tag=%0d",
                 i, b_out_valid, b_out_imm, b_out_fmt, b_out_tag, exp[i], i);
      end
    end
  endtask

  task automatic test_x64_random();
    dec_t d;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      b_in_valid = 1'b1; b_in_instr = rand_instr(); b_in_tag = 8'(i);
      d = ref_decode(b_in_instr, 1'b1);
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (b_out_valid !== 1'b1 || b_out_imm !== d.imm || b_out_fmt !== d.fmt || b_out_unknown !== d.unk) begin
        n_fail++;
        $display("FAIL x64_rand[%0d] instr=%h: got v=%b imm=%h fmt=%0d unk=%b, expected v=1 imm=%h fmt=%0d unk=%b",
                 i, b_in_instr, b_out_valid, b_out_imm, b_out_fmt, b_out_unknown, d.imm, d.fmt, d.unk);
      end
    end
  endtask

  task automatic drain_a(input string name);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && a_out_valid === 1'b0) break;
    end
    n_tests++;
    if (sb_q.size() != 0 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d pending, expected 0", name, sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      a_out_ready = (cyc >= 3);
      a_in_valid  = (k < 4);
      a_in_instr  = (k < 4) ? s_in[k] : 32'd0;
      a_in_tag    = 32'h200 + 32'(k);
      @(negedge clk);
      if (a_in_valid && a_in_ready === 1'b1) k++;
      if (cyc == 2) begin
        n_tests++;
        if (k != 2 || a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_imm !== s_imm[0]) begin
          n_fail++;
          $display("FAIL bp_stall: got acc=%0d rdy=%b v=%b imm=%h, expected acc=2 rdy=0 v=1 imm=%h",
                   k, a_in_ready, a_out_valid, a_out_imm, s_imm[0]);
        end
      end
    end
    n_tests++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL bp_accepted: got %0d, expected 4", k);
    end
    drain_a("bp");
  endtask

  task automatic test_unknown();
    @(posedge clk); #1; a_clr = 1'b1;
    @(posedge clk); #1; a_clr = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_cnt !== 16'd0) begin
      n_fail++; $display("FAIL unk_clear: got %0d, expected 0", a_cnt);
    end
    for (int i = 0; i <= 3; i++) begin
      @(posedge clk); #1;
      a_in_valid = (i < 3); a_in_instr = 32'h0000007F; a_in_tag = 32'h300 + 32'(i);
      @(negedge clk);
      n_tests++;
      if (a_cnt !== 16'(i)) begin
        n_fail++; $display("FAIL unk_count[%0d]: got %0d, expected %0d", i, a_cnt, i);
      end
      if (i > 0) begin
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_unknown !== 1'b1 || a_out_imm !== 32'd0 || a_out_fmt !== 3'd7) begin
          n_fail++;
          $display("FAIL unk_out[%0d]: got v=%b unk=%b imm=%h fmt=%0d, expected 1 1 0 7",
                   i, a_out_valid, a_out_unknown, a_out_imm, a_out_fmt);
        end
      end
    end
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_instr = 32'h0000007F; a_in_tag = 32'h3FF; a_clr = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_clr = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_cnt !== 16'd0) begin
      n_fail++; $display("FAIL unk_clr_wins: got %0d, expected 0", a_cnt);
    end
    drain_a("unk");
  endtask

  task automatic test_saturate();
    for (int i = 0; i <= 5; i++) begin
      @(posedge clk); #1;
      c_in_valid = (i < 5); c_in_instr = 32'h0000007F; c_in_tag = 8'(i);
      @(negedge clk);
      n_tests++;
      if (c_cnt !== ((i < 3) ? 2'(i) : 2'd3)) begin
        n_fail++;
        $display("FAIL sat_count[%0d]: got %0d, expected %0d", i, c_cnt, (i < 3) ? i : 3);
      end
    end
    c_in_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      a_in_valid  = ($urandom_range(0, 9) < 7);
      a_in_instr  = rand_instr();
      a_in_tag    = $urandom();
      a_out_ready = ($urandom_range(0, 9) < 6);
    end
    drain_a("rand");
  endtask

  task automatic test_reset_midstream();
    @(posedge clk); #1;
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_instr = 32'h0000007F; a_in_tag = 32'h400;
    @(posedge clk); #1;
    a_in_tag = 32'h401;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_cnt === 16'd0) begin
      n_fail++;
      $display("FAIL rst_full: got rdy=%b v=%b cnt=%0d, expected rdy=0 v=1 cnt>0", a_in_ready, a_out_valid, a_cnt);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_async: got v=%b rdy=%b cnt=%0d, expected 0 1 0", a_out_valid, a_in_ready, a_cnt);
    end
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after: got rdy=%b v=%b, expected 1 0", a_in_ready, a_out_valid);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_instr = s_in[3]; a_in_tag = 32'h500;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_out_valid !== 1'b1 || a_out_imm !== s_imm[3] || a_out_tag !== 32'h500) begin
      n_fail++;
      $display("FAIL rst_resume: got v=%b imm=%h tag=%h, expected 1 %h 500", a_out_valid, a_out_imm, a_out_tag, s_imm[3]);
    end
    drain_a("rst");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_shifts();
    test_x64_random();
    test_backpressure();
    test_unknown();
    test_saturate();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected earlier finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
